// File: rtl/tick_prescaler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler_pkg
// Description : Shared state encoding and reset values for tick_prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_prescaler_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_TICK  = 1'b0;
    localparam logic   RST_DONE  = 1'b0;
    localparam logic   RST_CONT  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/reload_downcounter.sv
`default_nettype none
// ============================================================================
// Module      : reload_downcounter
// Description : W-bit down-counter with synchronous load and a zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module reload_downcounter
    import tick_prescaler_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_cnt;

    // Load wins over decrement so a reload at terminal count restarts the period.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - C_ONE;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Programmable clock-enable generator, continuous or burst mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import tick_prescaler_pkg::*;
#(
    parameter int unsigned W = 16,
    parameter int unsigned C = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] div,
    input  logic [C-1:0] burst,
    output logic         tick,
    output logic         busy,
    output logic         done,
    output logic [C-1:0] ticks_left
);

    localparam logic [C-1:0] C_ONE = {{(C-1){1'b0}}, 1'b1};

    state_t       r_state,      w_state_nxt;
    logic [W-1:0] r_div_q,      w_div_q_nxt;
    logic [C-1:0] r_ticks_left, w_ticks_left_nxt;
    logic         r_cont,       w_cont_nxt;
    logic         r_tick,       w_tick_nxt;
    logic         r_done,       w_done_nxt;

    logic         w_cnt_load;
    logic [W-1:0] w_cnt_load_val;
    logic         w_cnt_dec;
    logic         w_cnt_zero;

    reload_downcounter #(
        .W (W)
    ) u_cnt (
        .clk        (clk),
        .clr_n      (clr_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state      <= RST_STATE;
            r_div_q      <= '0;
            r_ticks_left <= '0;
            r_cont       <= RST_CONT;
            r_tick       <= RST_TICK;
            r_done       <= RST_DONE;
        end else begin
            r_state      <= w_state_nxt;
            r_div_q      <= w_div_q_nxt;
            r_ticks_left <= w_ticks_left_nxt;
            r_cont       <= w_cont_nxt;
            r_tick       <= w_tick_nxt;
            r_done       <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_div_q_nxt      = r_div_q;
        w_ticks_left_nxt = r_ticks_left;
        w_cont_nxt       = r_cont;
        w_tick_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        w_cnt_load       = 1'b0;
        w_cnt_load_val   = r_div_q;
        w_cnt_dec        = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_cnt_load       = 1'b1;
                    w_cnt_load_val   = div;
                    w_div_q_nxt      = div;
                    w_ticks_left_nxt = burst;
                    w_cont_nxt       = (burst == '0);
                    w_state_nxt      = RUN;
                end
            end
            RUN: begin
                // Stop outranks a tick falling due on the same edge.
                if (stop) begin
                    w_ticks_left_nxt = '0;
                    w_state_nxt      = IDLE;
                end else if (!w_cnt_zero) begin
                    w_cnt_dec = 1'b1;
                end else begin
                    w_tick_nxt     = 1'b1;
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = r_div_q;
                    if (!r_cont) begin
                        w_ticks_left_nxt = r_ticks_left - C_ONE;
                    end
                    if (r_ticks_left == C_ONE) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign tick       = r_tick;
    assign busy       = (r_state == RUN);
    assign done       = r_done;
    assign ticks_left = r_ticks_left;

endmodule
`default_nettype wire

// File: tb/tb_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_prescaler
// Description : Self-checking bench for tick_prescaler against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_prescaler;

    localparam int    W    = 16;
    localparam int    C    = 8;
    localparam longint HUGE = 64'h3fff_ffff_ffff_ffff;

    logic         clk = 1'b0;
    logic         clr_n;
    logic         start;
    logic         stop;
    logic [W-1:0] div;
    logic [C-1:0] burst;
    logic         tick;
    logic         busy;
    logic         done;
    logic [C-1:0] ticks_left;

    int n_chk = 0;
    int n_err = 0;
    int down_cnt = 0;
    longint cyc = 0;

    // Run described as a timeline: accepted at edge m_k, idle again from edge m_end.
    bit     m_have;
    bit     m_cont;
    bit     m_stopped;
    longint m_k;
    longint m_end;
    longint m_d;
    longint m_b;

    tick_prescaler #(
        .W (W),
        .C (C)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .start      (start),
        .stop       (stop),
        .div        (div),
        .burst      (burst),
        .tick       (tick),
        .busy       (busy),
        .done       (done),
        .ticks_left (ticks_left)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tick) down_cnt <= down_cnt + 1;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit m_busy(input longint e);
        return m_have && (e >= m_k) && (e < m_end);
    endfunction

    function automatic bit m_tick(input longint e);
        if (!m_have || e <= m_k) return 1'b0;
        if (((e - m_k) % (m_d + 1)) != 0) return 1'b0;
        return (e < m_end) || ((e == m_end) && !m_stopped);
    endfunction

    function automatic int m_left(input longint e);
        if (!m_have || m_cont || e >= m_end || e < m_k) return 0;
        return int'(m_b - (e - m_k) / (m_d + 1));
    endfunction

    function automatic bit m_done(input longint e);
        return m_have && !m_cont && !m_stopped && (e == m_end);
    endfunction

    task automatic check_all();
        check_eq("tick",       int'(tick),       int'(m_tick(cyc)));
        check_eq("busy",       int'(busy),       int'(m_busy(cyc)));
        check_eq("done",       int'(done),       int'(m_done(cyc)));
        check_eq("ticks_left", int'(ticks_left), m_left(cyc));
    endtask

    // Drive one cycle of inputs (at a negedge), advance the model, check after the edge.
    task automatic step(input bit s_start, input bit s_stop, input int s_div, input int s_burst);
        longint e;
        start = s_start;
        stop  = s_stop;
        div   = s_div[W-1:0];
        burst = s_burst[C-1:0];
        e = cyc + 1;
        if (m_busy(cyc)) begin
            if (s_stop) begin
                m_end     = e;
                m_stopped = 1'b1;
            end
        end else if (s_start) begin
            m_have    = 1'b1;
            m_k       = e;
            m_d       = longint'(s_div);
            m_b       = longint'(s_burst);
            m_cont    = (s_burst == 0);
            m_stopped = 1'b0;
            m_end     = m_cont ? HUGE : e + m_b * (m_d + 1);
        end
        @(posedge clk);
        cyc = e;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        int c0;
        m_have = 1'b0;
        m_cont = 1'b0;
        m_stopped = 1'b0;
        m_k = 0; m_end = 0; m_d = 0; m_b = 0;
        clr_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        div   = '0;
        burst = '0;
        repeat (2) @(negedge clk);
        check_all();
        clr_n = 1'b1;

        // Continuous, period 5, across ten ticks.
        step(1'b1, 1'b0, 4, 0);
        idle(52);
        step(1'b0, 1'b1, 0, 0);
        idle(2);

        // Burst of three, period 3.
        step(1'b1, 1'b0, 2, 3);
        idle(12);

        // div=0 burst of five: consecutive ticks, downstream counter +5.
        c0 = down_cnt;
        step(1'b1, 1'b0, 0, 5);
        idle(8);
        check_eq("burst_count", down_cnt - c0, 5);

        // Stop on the edge where a tick is due.
        step(1'b1, 1'b0, 7, 0);
        idle(7);
        step(1'b0, 1'b1, 0, 0);
        idle(12);

        // start held and div changed mid-run are ignored.
        step(1'b1, 1'b0, 3, 0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 9, 2);
        step(1'b0, 1'b1, 0, 0);
        idle(2);

        // start held through done cycles: back-to-back bursts.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1, 2);
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
        end
        step(1'b0, 1'b1, 0, 0);
        idle(3);

        // Asynchronous reset mid-run, between edges.
        step(1'b1, 1'b0, 3, 0);
        idle(6);
        #2 clr_n = 1'b0;
        #1;
        check_eq("rst_tick",  int'(tick),       0);
        check_eq("rst_busy",  int'(busy),       0);
        check_eq("rst_done",  int'(done),       0);
        check_eq("rst_left",  int'(ticks_left), 0);
        m_have = 1'b0;
        @(negedge clk);
        check_all();
        clr_n = 1'b1;
        idle(3);
        step(1'b1, 1'b0, 1, 2);
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
